// File: rtl/mem_bus_master.sv
// mem_bus_master: burst master for the shared main bus.
// Each transaction is one address phase followed by a fixed-length data burst.
// Write beats are driven onto AddrData. Read beats are captured from it. The
// finished read burst and a one-cycle done pulse are returned to the requester.
//
// Requester handshake: ready=1 means the block is idle. A transaction is
// accepted on a posedge where req=1 and ready=1, and rwIn/addrIn/wrBurst are
// captured on that same edge. A req seen while ready=0 is dropped, not queued.
// The one exception is a req still held high when DONE ends: it is taken on
// that edge, which keeps back-to-back address phases DATAPAYLOADSIZE+2 cycles
// apart.
module mem_bus_master #(
    parameter int DATAWIDTH       = 16,
    parameter int DATAPAYLOADSIZE = 4
) (
    input  logic                                 clk,
    input  logic                                 resetH,
    input  logic                                 req,
    output logic                                 ready,
    input  logic                                 rwIn,
    input  logic [15:0]                          addrIn,
    input  logic [DATAWIDTH*DATAPAYLOADSIZE-1:0] wrBurst,
    output logic [DATAWIDTH*DATAPAYLOADSIZE-1:0] rdBurst,
    output logic                                 done,
    output logic                                 AddrValid,
    output logic                                 rw,
    inout  wire  [DATAWIDTH-1:0]                 AddrData,
    output logic [1:0]                           state_dbg
);

    localparam int BW     = $clog2(DATAPAYLOADSIZE) + 1;
    localparam int BURSTW = DATAWIDTH * DATAPAYLOADSIZE;
    localparam logic [BW-1:0] LAST_BEAT = BW'(DATAPAYLOADSIZE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [BW-1:0]        beat;
    logic                 rw_q;
    logic [15:0]          addr_q;
    logic [BURSTW-1:0]    wr_q;
    logic [BURSTW-1:0]    rd_stage;
    logic [BURSTW-1:0]    stage_next;
    logic [BURSTW-1:0]    rd_q;
    logic                 accept;
    logic                 drive_en;
    logic [DATAWIDTH-1:0] drive_val;

    // A new transaction is taken from IDLE, or directly out of DONE when req is held.
    assign accept = req && ((state == IDLE) || (state == DONE));

    // State register; reset drops straight to IDLE, which releases the bus at once.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the outputs decoded from the current state.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        AddrValid  = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (req) state_next = ADDR;
            end
            ADDR: begin
                AddrValid  = 1'b1;
                state_next = DATA;
            end
            DATA: begin
                if (beat == LAST_BEAT) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = req ? ADDR : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Beat counter: cleared in the address phase and advanced once per data cycle.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            beat <= '0;
        end else if (state == ADDR) begin
            beat <= '0;
        end else if (state == DATA) begin
            beat <= beat + 1'b1;
        end
    end

    // Request capture; these registers stay stable for the whole transaction.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            rw_q   <= 1'b0;
            addr_q <= '0;
            wr_q   <= '0;
        end else if (accept) begin
            rw_q   <= rwIn;
            addr_q <= addrIn;
            wr_q   <= wrBurst;
        end
    end

    // Staging copy with the current bus value merged into the active beat slot.
    always_comb begin
        stage_next = rd_stage;
        stage_next[int'(beat)*DATAWIDTH +: DATAWIDTH] = AddrData;
    end

    // Read beats collect in a staging buffer. rdBurst is updated only when the last
    // beat lands, so a burst cut short by reset never reaches the requester.
    always_ff @(posedge clk or posedge resetH) begin
        if (resetH) begin
            rd_stage <= '0;
            rd_q     <= '0;
        end else if ((state == DATA) && rw_q) begin
            rd_stage <= stage_next;
            if (beat == LAST_BEAT) rd_q <= stage_next;
        end
    end

    // The bus is driven only in the address phase and in the data cycles of a write.
    always_comb begin
        drive_en  = 1'b0;
        drive_val = '0;
        if (state == ADDR) begin
            drive_en  = 1'b1;
            drive_val = DATAWIDTH'(addr_q);
        end else if ((state == DATA) && !rw_q) begin
            drive_en  = 1'b1;
            drive_val = wr_q[int'(beat)*DATAWIDTH +: DATAWIDTH];
        end
    end

    assign AddrData  = drive_en ? drive_val : 'z;
    assign rw        = rw_q;
    assign rdBurst   = rd_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: table of whole transactions plus hand sequences
// for reset mid-burst, busy rejection, back-to-back and unmapped-page reads.
// A small paged slave on page 1 sits on AddrData as the bus partner.
module tb_mem_bus_master;

    localparam int W = 16;
    localparam int P = 4;

    logic           clk;
    logic           resetH;
    logic           req;
    logic           ready;
    logic           rwIn;
    logic [15:0]    addrIn;
    logic [W*P-1:0] wrBurst;
    logic [W*P-1:0] rdBurst;
    logic           done;
    logic           AddrValid;
    logic           rw;
    wire  [W-1:0]   AddrData;
    logic [1:0]     state_dbg;

    int total = 0;
    int bad   = 0;
    logic [W*P-1:0] last_rd;

    typedef struct {
        logic           rw;
        logic [15:0]    addr;
        logic [W*P-1:0] wr;
        logic [W*P-1:0] exp_rd;
    } vec_t;

    vec_t vecs[5];

    mem_bus_master #(.DATAWIDTH(W), .DATAPAYLOADSIZE(P)) dut (
        .clk       (clk),
        .resetH    (resetH),
        .req       (req),
        .ready     (ready),
        .rwIn      (rwIn),
        .addrIn    (addrIn),
        .wrBurst   (wrBurst),
        .rdBurst   (rdBurst),
        .done      (done),
        .AddrValid (AddrValid),
        .rw        (rw),
        .AddrData  (AddrData),
        .state_dbg (state_dbg)
    );

    // clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // paged slave on page 1: latches the address phase, then serves P beats
    logic [W-1:0] mem [4096];
    logic         s_act;
    logic         s_rw;
    logic [15:0]  s_addr;
    int           s_cnt;
    logic         slave_en;
    logic [W-1:0] slave_val;

    always @(posedge clk or posedge resetH) begin
        if (resetH) begin
            s_act  <= 1'b0;
            s_rw   <= 1'b0;
            s_addr <= '0;
            s_cnt  <= 0;
            for (int i = 0; i < 4096; i++) mem[i] <= 16'h1100 + 16'(i);
        end else if (AddrValid) begin
            s_act  <= 1'b1;
            s_rw   <= rw;
            s_addr <= AddrData;
            s_cnt  <= 0;
        end else if (s_act) begin
            if (!s_rw && (s_addr[15:12] == 4'h1))
                mem[12'(s_addr[11:0] + s_cnt[11:0])] <= AddrData;
            if (s_cnt == P - 1) s_act <= 1'b0;
            s_cnt <= s_cnt + 1;
        end
    end

    assign slave_en  = s_act && s_rw && (s_addr[15:12] == 4'h1);
    assign slave_val = mem[12'(s_addr[11:0] + s_cnt[11:0])];
    assign AddrData  = slave_en ? slave_val : 'z;

    // scoreboard helpers
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // master must not drive: the bus reads as released (z, or 0 on a 2-state sim)
    task automatic chk_float(input string name);
        total++;
        if (!((AddrData === {W{1'bz}}) || (AddrData === {W{1'b0}}))) begin
            bad++;
            $display("FAIL %s: bus shows %h, expected released", name, AddrData);
        end
    endtask

    // one full transaction from IDLE, checked cycle by cycle
    task automatic run_txn(input vec_t v, input int idx);
        logic [W*P-1:0] exp_final;
        chk($sformatf("v%0d ready_pre", idx), 64'(ready), 64'd1);
        rwIn = v.rw; addrIn = v.addr; wrBurst = v.wr; req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        chk($sformatf("v%0d addr_valid", idx), 64'(AddrValid), 64'd1);
        chk($sformatf("v%0d addr_bus", idx), 64'(AddrData), 64'(v.addr));
        chk($sformatf("v%0d addr_rw", idx), 64'(rw), 64'(v.rw));
        chk($sformatf("v%0d addr_ready", idx), 64'(ready), 64'd0);
        for (int b = 0; b < P; b++) begin
            @(negedge clk);
            chk($sformatf("v%0d b%0d valid", idx, b), 64'(AddrValid), 64'd0);
            chk($sformatf("v%0d b%0d rw", idx, b), 64'(rw), 64'(v.rw));
            if (v.rw)
                chk($sformatf("v%0d b%0d rd_bus", idx, b), 64'(AddrData), 64'(v.exp_rd[b*W +: W]));
            else
                chk($sformatf("v%0d b%0d wr_bus", idx, b), 64'(AddrData), 64'(v.wr[b*W +: W]));
            chk($sformatf("v%0d b%0d rd_hold", idx, b), rdBurst, last_rd);
        end
        @(negedge clk);
        exp_final = v.rw ? v.exp_rd : last_rd;
        chk($sformatf("v%0d done", idx), 64'(done), 64'd1);
        chk($sformatf("v%0d done_ready", idx), 64'(ready), 64'd0);
        chk_float($sformatf("v%0d done_bus", idx));
        chk($sformatf("v%0d rdburst", idx), rdBurst, exp_final);
        last_rd = exp_final;
        @(negedge clk);
        chk($sformatf("v%0d ready_back", idx), 64'(ready), 64'd1);
        chk($sformatf("v%0d done_low", idx), 64'(done), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h1010, 64'h00D4_00C3_00B2_00A1, 64'h0};
        vecs[1] = '{1'b1, 16'h1010, 64'h0, 64'h00D4_00C3_00B2_00A1};
        vecs[2] = '{1'b1, 16'h1FFC, 64'h0, 64'h20FF_20FE_20FD_20FC};
        vecs[3] = '{1'b0, 16'h1020, 64'h4444_3333_2222_1111, 64'h0};
        vecs[4] = '{1'b1, 16'h1022, 64'h0, 64'h1125_1124_4444_3333};

        // reset block
        resetH = 1'b1; req = 1'b0; rwIn = 1'b0; addrIn = '0; wrBurst = '0;
        repeat (3) @(negedge clk);
        chk("rst ready", 64'(ready), 64'd1);
        chk("rst done", 64'(done), 64'd0);
        chk("rst addr_valid", 64'(AddrValid), 64'd0);
        chk("rst rw", 64'(rw), 64'd0);
        chk("rst rdburst", rdBurst, 64'd0);
        chk("rst state", 64'(state_dbg), 64'd0);
        chk_float("rst bus");
        resetH = 1'b0;
        @(negedge clk);
        last_rd = '0;

        // reset during beat 2 of a read
        begin
            int dones = 0;
            rwIn = 1'b1; addrIn = 16'h1010; req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            repeat (3) @(negedge clk);
            resetH = 1'b1;
            #1;
            chk("midrst ready", 64'(ready), 64'd1);
            chk("midrst addr_valid", 64'(AddrValid), 64'd0);
            chk("midrst done", 64'(done), 64'd0);
            chk("midrst rdburst", rdBurst, last_rd);
            chk_float("midrst bus");
            @(negedge clk);
            resetH = 1'b0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (done) dones++;
            end
            chk("midrst no_done", 64'(dones), 64'd0);
            chk("midrst rd_after", rdBurst, last_rd);
        end

        // table-driven transactions
        for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

        // busy rejection: req to 0x2000 during DATA of a read is dropped
        begin
            int avs = 0;
            int dones = 0;
            rwIn = 1'b1; addrIn = 16'h1010; wrBurst = '0; req = 1'b1;
            for (int c = 0; c < 12; c++) begin
                @(negedge clk);
                if (c == 0) req = 1'b0;
                if (AddrValid) avs++;
                if (done) dones++;
                if (c == 2) begin rwIn = 1'b0; addrIn = 16'h2000; req = 1'b1; end
                if (c == 3) begin
                    req = 1'b0;
                    chk("busy rd_hold", rdBurst, last_rd);
                end
            end
            chk("busy addr_phases", 64'(avs), 64'd1);
            chk("busy dones", 64'(dones), 64'd1);
            chk("busy rdburst", rdBurst, 64'h00D4_00C3_00B2_00A1);
            last_rd = 64'h00D4_00C3_00B2_00A1;
        end

        // back-to-back: write 0x1000 then read it with req held high
        begin
            logic [W*P-1:0] bb;
            int first_a = -1;
            int second_a = -1;
            int dones = 0;
            bb = 64'hCAFE_BEEF_1357_2468;
            rwIn = 1'b0; addrIn = 16'h1000; wrBurst = bb; req = 1'b1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (done) dones++;
                if (AddrValid) begin
                    if (first_a < 0) begin
                        first_a = c;
                        rwIn = 1'b1;
                    end else if (second_a < 0) begin
                        second_a = c;
                        req = 1'b0;
                    end
                end
                if ((first_a >= 0) && (c > first_a) && (c <= first_a + P))
                    chk($sformatf("b2b wr_bus c%0d", c), 64'(AddrData), 64'(bb[(c-first_a-1)*W +: W]));
                if ((first_a >= 0) && (c == first_a + P + 1))
                    chk_float("b2b done_bus");
                if ((second_a >= 0) && (c > second_a) && (c <= second_a + P))
                    chk($sformatf("b2b rd_bus c%0d", c), 64'(AddrData), 64'(bb[(c-second_a-1)*W +: W]));
            end
            req = 1'b0;
            chk("b2b gap", 64'(second_a - first_a), 64'd6);
            chk("b2b dones", 64'(dones), 64'd2);
            chk("b2b rdburst", rdBurst, bb);
        end

        // unmapped page: read 0xF000 still completes, master never drives in DATA
        begin
            rwIn = 1'b1; addrIn = 16'hF000; req = 1'b1;
            @(negedge clk);
            req = 1'b0;
            chk("unmap addr_valid", 64'(AddrValid), 64'd1);
            chk("unmap addr_bus", 64'(AddrData), 64'hF000);
            for (int b = 0; b < P; b++) begin
                @(negedge clk);
                chk_float($sformatf("unmap b%0d bus", b));
            end
            @(negedge clk);
            chk("unmap done", 64'(done), 64'd1);
            @(negedge clk);
            chk("unmap ready", 64'(ready), 64'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
